// File: rtl/serializer_ctrl_pkg.sv
// Shared types and sizing constants for the parallel-to-serial controller.
package serializer_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/ff.sv
// Downstream 1-bit enable flip-flop cell fed by the serializer.
module FF (
  input  logic CLK,
  input  logic EN,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK) begin
    if (EN) Q <= D;
  end

endmodule

// File: rtl/serializer_ctrl_shift_reg_load.sv
// Left-shift register with parallel load, shift enable and async clear; exposes MSB.
module shift_reg_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)          sr_d = din;
    else if (shift_en) sr_d = {sr_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serializer_ctrl.sv
// Accepts a word over valid/ready and strobes it MSB-first into an FF chain,
// with HOLD stalls and a one-cycle DONE pulse after the last bit.
module serializer_ctrl
  import serializer_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  input  logic             HOLD,
  output logic             READY_OUT,
  output logic             D_OUT,
  output logic             EN_OUT,
  output logic             DONE
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load, shift_en, msb;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (VALID_IN) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!HOLD) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  shift_reg_load #(.WIDTH(WIDTH)) u_sr (
    .clk      (CLK),
    .rst_n    (RESET_L),
    .load     (load),
    .shift_en (shift_en),
    .din      (DATA_IN),
    .msb      (msb)
  );

  // Gated with RESET_L so READY drops the instant reset asserts.
  assign READY_OUT = RESET_L & (state_q == ST_IDLE);
  assign EN_OUT    = (state_q == ST_SHIFT) & ~HOLD;
  assign D_OUT     = (state_q == ST_SHIFT) & msb;
  assign DONE      = done_q;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed bench: serializer_ctrl driving an 8-deep FF chain.
module tb_serializer_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       VALID_IN = 1'b0;
  logic       HOLD = 1'b0;
  logic       READY_OUT, D_OUT, EN_OUT, DONE;
  logic [7:0] chain_q;
  logic [7:0] chain_d;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  serializer_ctrl #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .DATA_IN   (DATA_IN),
    .VALID_IN  (VALID_IN),
    .HOLD      (HOLD),
    .READY_OUT (READY_OUT),
    .D_OUT     (D_OUT),
    .EN_OUT    (EN_OUT),
    .DONE      (DONE)
  );

  assign chain_d = {chain_q[6:0], D_OUT};
  for (genvar g = 0; g < 8; g++) begin : g_chain
    FF u_ff (.CLK(CLK), .EN(EN_OUT), .D(chain_d[g]), .Q(chain_q[g]));
  end

  // Inputs change at posedge+1, outputs are sampled at negedge.
  task automatic test_reset();
    RESET_L = 1'b0; VALID_IN = 1'b1; DATA_IN = 8'hFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (READY_OUT !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", READY_OUT); end
    checks++; if (EN_OUT !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", EN_OUT); end
    checks++; if (D_OUT !== 1'b0) begin failures++; $display("FAIL rst_d got=%b exp=0", D_OUT); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", DONE); end
    @(posedge CLK); #1;
    RESET_L = 1'b1; VALID_IN = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++; if (READY_OUT !== 1'b1) begin failures++; $display("FAIL rel_ready c=%0d got=%b exp=1", c, READY_OUT); end
      checks++; if (EN_OUT !== 1'b0) begin failures++; $display("FAIL rel_en c=%0d got=%b exp=0", c, EN_OUT); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    DATA_IN = w; VALID_IN = 1'b1;
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++; if (EN_OUT !== 1'b1) begin failures++; $display("FAIL a5_en bit=%0d got=%b exp=1", c, EN_OUT); end
      checks++; if (D_OUT !== w[7-c]) begin failures++; $display("FAIL a5_d bit=%0d got=%b exp=%b", c, D_OUT, w[7-c]); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL a5_early_done bit=%0d got=%b exp=0", c, DONE); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL a5_done got=%b exp=1", DONE); end
    checks++; if (EN_OUT !== 1'b0) begin failures++; $display("FAIL a5_done_en got=%b exp=0", EN_OUT); end
    checks++; if (chain_q !== 8'hA5) begin failures++; $display("FAIL a5_chain got=%h exp=a5", chain_q); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL a5_done_pulse got=%b exp=0", DONE); end
    checks++; if (READY_OUT !== 1'b1) begin failures++; $display("FAIL a5_idle_ready got=%b exp=1", READY_OUT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_hold();
    logic [7:0] w;
    int         bi;
    w = 8'hA5;
    DATA_IN = w; VALID_IN = 1'b1;
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 11; c++) begin
      HOLD = (c >= 2 && c < 5);
      bi = (c < 2) ? c : ((c < 5) ? 2 : c - 3);
      @(negedge CLK);
      checks++; if (EN_OUT !== !HOLD) begin failures++; $display("FAIL hold_en c=%0d got=%b exp=%b", c, EN_OUT, !HOLD); end
      checks++; if (D_OUT !== w[7-bi]) begin failures++; $display("FAIL hold_d c=%0d got=%b exp=%b", c, D_OUT, w[7-bi]); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL hold_early_done c=%0d got=%b exp=0", c, DONE); end
      @(posedge CLK); #1;
    end
    HOLD = 1'b0;
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", DONE); end
    checks++; if (chain_q !== 8'hA5) begin failures++; $display("FAIL hold_chain got=%h exp=a5", chain_q); end
    @(posedge CLK); #1;
  endtask

  task automatic test_valid_ignored();
    logic [7:0] w;
    w = 8'h3C;
    DATA_IN = w; VALID_IN = 1'b1;
    @(posedge CLK); #1;
    DATA_IN = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++; if (READY_OUT !== 1'b0) begin failures++; $display("FAIL ign_ready bit=%0d got=%b exp=0", c, READY_OUT); end
      checks++; if (EN_OUT !== 1'b1) begin failures++; $display("FAIL ign_en bit=%0d got=%b exp=1", c, EN_OUT); end
      checks++; if (D_OUT !== w[7-c]) begin failures++; $display("FAIL ign_d bit=%0d got=%b exp=%b", c, D_OUT, w[7-c]); end
      @(posedge CLK); #1;
    end
    VALID_IN = 1'b0;
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", DONE); end
    checks++; if (chain_q !== 8'h3C) begin failures++; $display("FAIL ign_chain got=%h exp=3c", chain_q); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (EN_OUT !== 1'b0) begin failures++; $display("FAIL ign_no_accept got=%b exp=0", EN_OUT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    w0 = 8'h3C; w1 = 8'hC3;
    DATA_IN = w0; VALID_IN = 1'b1;
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++; if (D_OUT !== w0[7-c] || EN_OUT !== 1'b1) begin failures++; $display("FAIL b2b_w0 bit=%0d got=%b/%b exp=%b/1", c, D_OUT, EN_OUT, w0[7-c]); end
      @(posedge CLK); #1;
    end
    DATA_IN = w1; VALID_IN = 1'b1;
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_done0 got=%b exp=1", DONE); end
    checks++; if (READY_OUT !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", READY_OUT); end
    checks++; if (EN_OUT !== 1'b0) begin failures++; $display("FAIL b2b_gap_en got=%b exp=0", EN_OUT); end
    checks++; if (chain_q !== w0) begin failures++; $display("FAIL b2b_chain0 got=%h exp=%h", chain_q, w0); end
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++; if (D_OUT !== w1[7-c] || EN_OUT !== 1'b1) begin failures++; $display("FAIL b2b_w1 bit=%0d got=%b/%b exp=%b/1", c, D_OUT, EN_OUT, w1[7-c]); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", DONE); end
    checks++; if (chain_q !== w1) begin failures++; $display("FAIL b2b_chain1 got=%h exp=%h", chain_q, w1); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'h5A;
    DATA_IN = w; VALID_IN = 1'b1;
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++; if (D_OUT !== w[4] || EN_OUT !== 1'b1) begin failures++; $display("FAIL mid_bit4 got=%b/%b exp=%b/1", D_OUT, EN_OUT, w[4]); end
    #2 RESET_L = 1'b0;
    #1;
    checks++; if ({READY_OUT, EN_OUT, D_OUT, DONE} !== 4'b0000) begin failures++; $display("FAIL mid_async got=%b exp=0000", {READY_OUT, EN_OUT, D_OUT, DONE}); end
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++; if (DONE !== 1'b0 || EN_OUT !== 1'b0) begin failures++; $display("FAIL mid_no_done c=%0d got=%b/%b exp=0/0", c, DONE, EN_OUT); end
      checks++; if (READY_OUT !== 1'b1) begin failures++; $display("FAIL mid_ready c=%0d got=%b exp=1", c, READY_OUT); end
      @(posedge CLK); #1;
    end
    w = 8'h81;
    DATA_IN = w; VALID_IN = 1'b1;
    @(posedge CLK); #1; VALID_IN = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++; if (D_OUT !== w[7-c] || EN_OUT !== 1'b1) begin failures++; $display("FAIL post_81 bit=%0d got=%b/%b exp=%b/1", c, D_OUT, EN_OUT, w[7-c]); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL post_81_done got=%b exp=1", DONE); end
    checks++; if (chain_q !== 8'h81) begin failures++; $display("FAIL post_81_chain got=%h exp=81", chain_q); end
    @(posedge CLK); #1;
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_basic();
    test_hold();
    test_valid_ignored();
    test_back_to_back();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
